video_timing: RTL and testbench



---
 rtl/video_timing_pkg.sv | 25 ++
 rtl/vt_axis.sv | 56 +++++
 rtl/video_timing.sv | 116 +++++++++++
 tb/tb_video_timing.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared constants and types for the raster timing generator.
// Default timing is a 64 x 312 character raster with a 48 x 256 visible area.
package video_timing_pkg;

  localparam int COL_W = 7;
  localparam int ROW_W = 9;

  localparam int H_TOTAL_DEF  = 64;
  localparam int H_VIS_DEF    = 48;
  localparam int HS_START_DEF = 52;
  localparam int HS_LEN_DEF   = 5;
  localparam int V_TOTAL_DEF  = 312;
  localparam int V_VIS_DEF    = 256;
  localparam int VS_START_DEF = 270;
  localparam int VS_LEN_DEF   = 4;

  // Sync pulses are active-high on this display path.
  typedef enum logic {
    SYNC_POS = 1'b0,
    SYNC_NEG = 1'b1
  } sync_pol_e;

  localparam sync_pol_e SYNC_POL = SYNC_POS;

endpackage

// File: rtl/vt_axis.sv
// vt_axis: one raster axis. Wrap counter with registered blank and sync window
// decodes, both taken from the next count so they line up with count_o.
// wrap_nxt_o is the combinational wrap condition used to step the next axis.
module vt_axis #(
  parameter int W = 7
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         step_i,
  input  logic [W-1:0] term_i,
  input  logic [W-1:0] blank_start_i,
  input  logic [W-1:0] sync_start_i,
  input  logic [W-1:0] sync_last_i,
  output logic [W-1:0] count_o,
  output logic         wrap_nxt_o,
  output logic         wrap_o,
  output logic         blank_o,
  output logic         sync_o
);

  logic [W-1:0] count_q, count_d;
  logic         wrap_q, blank_q, sync_q;
  logic         blank_d, sync_d;

  // Next count and window decodes of that next count.
  always_comb begin
    wrap_nxt_o = step_i && (count_q == term_i);
    count_d    = count_q;
    if (step_i) begin
      count_d = wrap_nxt_o ? '0 : count_q + W'(1);
    end
    blank_d = (count_d >= blank_start_i);
    sync_d  = (count_d >= sync_start_i) && (count_d <= sync_last_i);
  end

  // Count, wrap strobe and decodes all register together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      blank_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_nxt_o;
      blank_q <= blank_d;
      sync_q  <= sync_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = wrap_q;
  assign blank_o = blank_q;
  assign sync_o  = sync_q;

endmodule

// File: rtl/video_timing.sv
// video_timing: column/row raster timing from the prescaler carry strobe.
// Optional frame interrupt: define VIDEO_FRAME_IRQ_EN to build the IRQ/IACK
// handshake; otherwise IRQ is tied low and IACK is ignored.
module video_timing
  import video_timing_pkg::*;
#(
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int H_VIS    = H_VIS_DEF,
  parameter int HS_START = HS_START_DEF,
  parameter int HS_LEN   = HS_LEN_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF,
  parameter int V_VIS    = V_VIS_DEF,
  parameter int VS_START = VS_START_DEF,
  parameter int VS_LEN   = VS_LEN_DEF
) (
  input  logic             C,
  input  logic             R,
  input  logic             TICK,
  input  logic             EN,
  output logic [COL_W-1:0] COL,
  output logic [ROW_W-1:0] ROW,
  output logic             HBLANK,
  output logic             VBLANK,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             LEND,
  output logic             FEND,
  output logic             IRQ,
  input  logic             IACK
);

  if (H_TOTAL < 4 || H_TOTAL > 128) begin : g_bad_h_total
    $error("video_timing: H_TOTAL out of range");
  end
  if (H_VIS >= HS_START || HS_LEN < 1 || HS_START + HS_LEN > H_TOTAL) begin : g_bad_h_win
    $error("video_timing: horizontal window parameters inconsistent");
  end
  if (V_TOTAL < 4 || V_TOTAL > 512) begin : g_bad_v_total
    $error("video_timing: V_TOTAL out of range");
  end
  if (V_VIS < 1 || V_VIS >= VS_START || VS_LEN < 1 || VS_START + VS_LEN > V_TOTAL) begin : g_bad_v_win
    $error("video_timing: vertical window parameters inconsistent");
  end

  logic advance;
  logic col_wrap_nxt;
  logic unused_row_wrap_nxt;
  logic hs_raw, vs_raw;

  assign advance = EN & TICK;

  vt_axis #(.W(COL_W)) u_col (
    .clk_i        (C),
    .rst_i        (R),
    .step_i       (advance),
    .term_i       (COL_W'(H_TOTAL - 1)),
    .blank_start_i(COL_W'(H_VIS)),
    .sync_start_i (COL_W'(HS_START)),
    .sync_last_i  (COL_W'(HS_START + HS_LEN - 1)),
    .count_o      (COL),
    .wrap_nxt_o   (col_wrap_nxt),
    .wrap_o       (LEND),
    .blank_o      (HBLANK),
    .sync_o       (hs_raw)
  );

  // Row steps only on the advance that wraps the column; its wrap is frame end.
  vt_axis #(.W(ROW_W)) u_row (
    .clk_i        (C),
    .rst_i        (R),
    .step_i       (col_wrap_nxt),
    .term_i       (ROW_W'(V_TOTAL - 1)),
    .blank_start_i(ROW_W'(V_VIS)),
    .sync_start_i (ROW_W'(VS_START)),
    .sync_last_i  (ROW_W'(VS_START + VS_LEN - 1)),
    .count_o      (ROW),
    .wrap_nxt_o   (unused_row_wrap_nxt),
    .wrap_o       (FEND),
    .blank_o      (VBLANK),
    .sync_o       (vs_raw)
  );

  assign HSYNC = hs_raw ^ (SYNC_POL == SYNC_NEG);
  assign VSYNC = vs_raw ^ (SYNC_POL == SYNC_NEG);

`ifdef VIDEO_FRAME_IRQ_EN
  logic irq_q, irq_d, irq_set;

  // Set at entry to vertical blanking; acknowledge clears, set has priority.
  always_comb begin
    irq_set = col_wrap_nxt && (ROW == ROW_W'(V_VIS - 1));
    irq_d   = irq_q;
    if (irq_set) begin
      irq_d = 1'b1;
    end else if (IACK) begin
      irq_d = 1'b0;
    end
  end

  // Interrupt request flop.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign IRQ = irq_q;
`else
  logic unused_iack;
  assign unused_iack = IACK;
  assign IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_video_timing.sv
// tb_video_timing: scoreboard bench for video_timing with default parameters.
// Expected outputs come from a behavioural raster model; define
// VIDEO_FRAME_IRQ_EN consistently for bench and design to cover the IRQ path.
module tb_video_timing;

  typedef struct packed {
    logic [6:0] col;
    logic [8:0] row;
    logic       hblank;
    logic       vblank;
    logic       hsync;
    logic       vsync;
    logic       lend;
    logic       fend;
    logic       irq;
  } obs_t;

  logic       C = 1'b0;
  logic       R = 1'b1;
  logic       TICK = 1'b0;
  logic       EN = 1'b0;
  logic       IACK = 1'b0;
  logic [6:0] COL;
  logic [8:0] ROW;
  logic       HBLANK, VBLANK, HSYNC, VSYNC, LEND, FEND, IRQ;

  int errors = 0;
  int checks = 0;

  int   m_col = 0;
  int   m_row = 0;
  logic m_lend = 1'b0;
  logic m_fend = 1'b0;
  logic m_irq = 1'b0;

  obs_t exp_q[$];
  obs_t e, o;

  video_timing dut (
    .C     (C),
    .R     (R),
    .TICK  (TICK),
    .EN    (EN),
    .COL   (COL),
    .ROW   (ROW),
    .HBLANK(HBLANK),
    .VBLANK(VBLANK),
    .HSYNC (HSYNC),
    .VSYNC (VSYNC),
    .LEND  (LEND),
    .FEND  (FEND),
    .IRQ   (IRQ),
    .IACK  (IACK)
  );

  always #5 C = ~C;

  function automatic obs_t observe();
    obs_t r;
    r.col = COL; r.row = ROW; r.hblank = HBLANK; r.vblank = VBLANK;
    r.hsync = HSYNC; r.vsync = VSYNC; r.lend = LEND; r.fend = FEND; r.irq = IRQ;
    return r;
  endfunction

  function automatic obs_t model_exp();
    obs_t r;
    r.col    = 7'(m_col);
    r.row    = 9'(m_row);
    r.hblank = (m_col >= 48);
    r.vblank = (m_row >= 256);
    r.hsync  = (m_col >= 52) && (m_col < 57);
    r.vsync  = (m_row >= 270) && (m_row < 274);
    r.lend   = m_lend;
    r.fend   = m_fend;
    r.irq    = m_irq;
    return r;
  endfunction

  task automatic model_reset();
    m_col = 0; m_row = 0; m_lend = 1'b0; m_fend = 1'b0; m_irq = 1'b0;
    exp_q.delete();
  endtask

  // Drive one clock of stimulus, advance the model, queue the expectation.
  task automatic drive_cycle(input logic tick, input logic en, input logic iack);
    logic set;
    @(negedge C);
    TICK = tick; EN = en; IACK = iack;
    set = 1'b0;
    m_lend = 1'b0;
    m_fend = 1'b0;
    if (tick && en) begin
      if (m_col == 63) begin
        m_col = 0;
        m_lend = 1'b1;
        if (m_row == 255) set = 1'b1;
        if (m_row == 311) begin
          m_row = 0;
          m_fend = 1'b1;
        end else begin
          m_row++;
        end
      end else begin
        m_col++;
      end
    end
`ifdef VIDEO_FRAME_IRQ_EN
    if (set) m_irq = 1'b1;
    else if (iack) m_irq = 1'b0;
`else
    m_irq = 1'b0;
`endif
    exp_q.push_back(model_exp());
    @(posedge C);
    #1;
  endtask

  task automatic test_reset();
    R = 1'b1; TICK = 1'b0; EN = 1'b0; IACK = 1'b0;
    model_reset();
    repeat (3) @(posedge C);
    #1;
    o = observe();
    checks++;
    if (o !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_state: got %h, expected %h", o, obs_t'(0));
    end
    @(negedge C);
    R = 1'b0;
  endtask

  task automatic test_hblank();
    for (int i = 0; i < 48; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0);
      e = exp_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL hblank_run[%0d]: got %h, expected %h", i, o, e);
      end
      if (i == 46) begin
        checks++;
        if (COL !== 7'd47 || HBLANK !== 1'b0) begin
          errors++;
          $display("FAIL col47_visible: got COL=%0d HBLANK=%b, expected COL=47 HBLANK=0", COL, HBLANK);
        end
      end
    end
    checks++;
    if (COL !== 7'd48 || HBLANK !== 1'b1) begin
      errors++;
      $display("FAIL col48_blank: got COL=%0d HBLANK=%b, expected COL=48 HBLANK=1", COL, HBLANK);
    end
  endtask

  task automatic test_hsync();
    while (m_col != 51) begin
      drive_cycle(1'b1, 1'b1, 1'b0);
      void'(exp_q.pop_front());
    end
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0);
      e = exp_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL hsync_window[%0d]: got %h, expected %h", i, o, e);
      end
    end
    checks++;
    if (COL !== 7'd57 || HSYNC !== 1'b0) begin
      errors++;
      $display("FAIL hsync_end: got COL=%0d HSYNC=%b, expected COL=57 HSYNC=0", COL, HSYNC);
    end
  endtask

  task automatic test_line_wrap();
    while (!(m_col == 63 && m_row == 10)) begin
      drive_cycle(1'b1, 1'b1, 1'b0);
      e = exp_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL line_run: got %h, expected %h", o, e);
      end
    end
    drive_cycle(1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    o = observe();
    checks++;
    if (o !== e || COL !== 7'd0 || ROW !== 9'd11 || LEND !== 1'b1 || FEND !== 1'b0) begin
      errors++;
      $display("FAIL line_wrap: got %h, expected %h", o, e);
    end
    drive_cycle(1'b0, 1'b1, 1'b0);
    e = exp_q.pop_front();
    o = observe();
    checks++;
    if (o !== e || LEND !== 1'b0) begin
      errors++;
      $display("FAIL lend_one_cycle: got %h, expected %h", o, e);
    end
  endtask

  task automatic test_irq();
    while (!(m_col == 63 && m_row == 255)) begin
      drive_cycle(1'b1, 1'b1, 1'b0);
      e = exp_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL irq_run: got %h, expected %h", o, e);
      end
    end
    // IACK on the same edge as entry to blanking: set must win.
    drive_cycle(1'b1, 1'b1, 1'b1);
    e = exp_q.pop_front();
    o = observe();
    checks++;
    if (o !== e || ROW !== 9'd256 || VBLANK !== 1'b1) begin
      errors++;
      $display("FAIL irq_set_with_iack: got %h, expected %h", o, e);
    end
    drive_cycle(1'b0, 1'b1, 1'b0);
    e = exp_q.pop_front();
    o = observe();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL irq_held: got %h, expected %h", o, e);
    end
    drive_cycle(1'b0, 1'b1, 1'b1);
    e = exp_q.pop_front();
    o = observe();
    checks++;
    if (o !== e || IRQ !== 1'b0) begin
      errors++;
      $display("FAIL irq_ack_clear: got %h, expected %h", o, e);
    end
    drive_cycle(1'b1, 1'b1, 1'b1);
    e = exp_q.pop_front();
    o = observe();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL iack_idle: got %h, expected %h", o, e);
    end
  endtask

  task automatic test_frame_wrap();
    while (!(m_col == 63 && m_row == 311)) begin
      drive_cycle(1'b1, 1'b1, 1'b0);
      e = exp_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL frame_run: got %h, expected %h", o, e);
      end
    end
    drive_cycle(1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    o = observe();
    checks++;
    if (o !== e || COL !== 7'd0 || ROW !== 9'd0 || LEND !== 1'b1 || FEND !== 1'b1 ||
        VBLANK !== 1'b0 || VSYNC !== 1'b0) begin
      errors++;
      $display("FAIL frame_wrap: got %h, expected %h", o, e);
    end
    drive_cycle(1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    o = observe();
    checks++;
    if (o !== e || FEND !== 1'b0) begin
      errors++;
      $display("FAIL fend_one_cycle: got %h, expected %h", o, e);
    end
  endtask

  task automatic test_en_hold();
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL en_hold[%0d]: got %h, expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_async_reset();
    while (!(m_col == 30 && m_row == 200)) begin
      drive_cycle(1'b1, 1'b1, 1'b0);
      void'(exp_q.pop_front());
    end
    o = observe();
    checks++;
    if (o !== model_exp()) begin
      errors++;
      $display("FAIL pre_reset_pos: got %h, expected %h", o, model_exp());
    end
    @(negedge C);
    #1;
    R = 1'b1;
    #1;
    o = observe();
    checks++;
    if (o !== obs_t'(0)) begin
      errors++;
      $display("FAIL async_reset: got %h, expected %h", o, obs_t'(0));
    end
    model_reset();
    TICK = 1'b1; EN = 1'b1;
    @(posedge C);
    #1;
    o = observe();
    checks++;
    if (o !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_hold: got %h, expected %h", o, obs_t'(0));
    end
    @(negedge C);
    R = 1'b0;
    TICK = 1'b0;
    drive_cycle(1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    o = observe();
    checks++;
    if (o !== e || COL !== 7'd1) begin
      errors++;
      $display("FAIL resume_after_reset: got %h, expected %h", o, e);
    end
  endtask

  initial begin
    test_reset();
    test_hblank();
    test_hsync();
    test_line_wrap();
    test_irq();
    test_frame_wrap();
    test_en_hold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
